// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front end that deserialises command frames for the RAM and serialises read data on MISO
module spi_slave_ctrl #(
  parameter int MEM_WIDTH = 8,
  parameter int FRAME_W = MEM_WIDTH + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [FRAME_W-1:0]   rx_data,
  output logic                 rx_valid,
  input  logic [MEM_WIDTH-1:0] tx_data,
  input  logic                 tx_valid
);
  localparam int CW = $clog2(FRAME_W + 1);
  localparam int TW = $clog2(MEM_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  state_t state, next_state;
  logic [FRAME_W-1:0] shift;
  logic [FRAME_W-1:0] frame;
  logic [CW-1:0] bit_cnt;
  logic [MEM_WIDTH-1:0] tx_shift;
  logic [TW-1:0] tx_cnt;
  logic rd_addr_seen;
  logic receiving, frame_done, tx_start, tx_shifting;
  assign frame = {shift[FRAME_W-2:0], MOSI};
  assign receiving = !SS_n && state != IDLE && bit_cnt < CW'(FRAME_W);
  assign frame_done = receiving && bit_cnt == CW'(FRAME_W - 1);
  // tx_cnt: 0 waiting for RAM data, 1..MEM_WIDTH-1 shifting, MEM_WIDTH response finished
  assign tx_start = !SS_n && state == READ_DATA && bit_cnt == CW'(FRAME_W) && tx_cnt == '0 && tx_valid;
  assign tx_shifting = !SS_n && state == READ_DATA && tx_cnt != '0 && tx_cnt < TW'(MEM_WIDTH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (state == IDLE) next_state = SS_n ? IDLE : CHK_CMD;
    else if (SS_n) next_state = IDLE;
    else if (state == CHK_CMD) next_state = !MOSI ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shift <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      MISO <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_shift <= '0;
      tx_cnt <= '0;
    end else begin
      rx_valid <= frame_done;
      MISO <= 1'b0;
      if (SS_n || state == IDLE) begin
        bit_cnt <= '0;
        tx_cnt <= '0;
      end
      if (receiving) begin
        shift <= frame;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (frame_done) begin
        rx_data <= frame;
        if (frame[FRAME_W-1 -: 2] == 2'b10) rd_addr_seen <= 1'b1;
      end
      if (tx_start) begin
        MISO <= tx_data[MEM_WIDTH-1];
        tx_shift <= {tx_data[MEM_WIDTH-2:0], 1'b0};
        tx_cnt <= TW'(1);
      end else if (tx_shifting) begin
        MISO <= tx_shift[MEM_WIDTH-1];
        tx_shift <= tx_shift << 1;
        tx_cnt <= tx_cnt + 1'b1;
        if (tx_cnt == TW'(MEM_WIDTH - 1)) rd_addr_seen <= 1'b0;
      end
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed and randomized frames checked against a frame-level model of the SPI slave
module tb_spi_slave_ctrl;
  logic clk = 1'b0;
  logic rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;
  int passed = 0, failed = 0, total = 0;
  int cyc, pulses, pulse_at, quiet_err;
  bit quiet;
  bit seen_m;
  logic [9:0] got, last_rx;
  spi_slave_ctrl dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid === 1'b1) begin
      pulses++;
      pulse_at = cyc;
      got = rx_data;
    end
    if (quiet && MISO !== 1'b0) quiet_err++;
  endtask
  task automatic jitter();
    MOSI = 1'($urandom);
    tx_valid = 1'($urandom);
    tx_data = 8'($urandom);
  endtask
  // ab: bits sampled before SS_n rises (-1 = full frame); tx_ab: response bits before abort (0 = full)
  task automatic do_frame(input logic [9:0] f, input int ab, input int tx_ab, input int dly);
    bit rd;
    logic [7:0] v, seq;
    int n;
    rd = f[9] && seen_m;
    cyc = -1; pulses = 0; pulse_at = -1; got = '0; quiet_err = 0; quiet = 1;
    SS_n = 1'b0;
    jitter();
    step();
    for (int i = 9; i >= 0 && (9 - i) != ab; i--) begin
      jitter();
      MOSI = f[i];
      step();
    end
    if (ab < 0) begin
      last_rx = f;
      if (f[9:8] == 2'b10) seen_m = 1'b1;
      if (rd) begin
        tx_valid = 1'b0;
        repeat (dly) begin
          MOSI = 1'($urandom);
          tx_data = 8'($urandom);
          step();
        end
        v = 8'($urandom);
        tx_data = v;
        tx_valid = 1'b1;
        quiet = 0; seq = '0; n = 0;
        repeat (tx_ab > 0 ? tx_ab : 8) begin
          step();
          seq = {seq[6:0], MISO};
          n++;
          jitter();
        end
        chk("miso_seq", 32'(seq), 32'(v >> (8 - n)));
        if (tx_ab == 0) seen_m = 1'b0;
        quiet = 1;
      end
      if (tx_ab == 0 || !rd)
        repeat (3) begin
          jitter();
          step();
        end
    end
    SS_n = 1'b1;
    jitter();
    step();
    chk("miso_quiet", 32'(quiet_err), 32'd0);
    chk("rx_pulses", 32'(pulses), (ab < 0) ? 32'd1 : 32'd0);
    if (ab < 0) begin
      chk("pulse_cycle", 32'(pulse_at), 32'd10);
      chk("rx_at_pulse", 32'(got), 32'(f));
    end
    chk("rx_data_hold", 32'(rx_data), 32'(last_rx));
  endtask
  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    seen_m = 1'b0; last_rx = '0; quiet = 0; cyc = 0; pulses = 0; quiet_err = 0;
    #1;
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_reset_miso", 32'(MISO), 32'd0);
    do_frame(10'h0A5, -1, 0, 0);
    do_frame(10'h13C, -1, 0, 0);
    do_frame(10'h207, -1, 0, 0);
    do_frame(10'h300, -1, 0, 2);
    do_frame(10'h0A5, 5, 0, 0);
    do_frame(10'h0FF, -1, 0, 0);
    do_frame(10'h3C5, -1, 0, 0);
    do_frame(10'h0F0, 9, 0, 0);
    do_frame(10'h2AA, 0, 0, 0);
    do_frame(10'h2AA, -1, 0, 0);
    do_frame(10'h311, -1, 4, 1);
    do_frame(10'h322, -1, 0, 0);
    do_frame(10'h3FF, -1, 0, 0);
    for (int k = 0; k < 70; k++) begin
      int ab, tx_ab;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
      tx_ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
      do_frame({2'($urandom_range(0, 3)), 8'($urandom)}, ab, tx_ab, int'($urandom_range(0, 4)));
    end
    if (!seen_m) do_frame(10'h25A, -1, 0, 0);
    cyc = -1; pulses = 0; quiet = 0;
    SS_n = 1'b0;
    step();
    for (int i = 9; i >= 0; i--) begin
      MOSI = 10'h3C3 >> i;
      step();
    end
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    repeat (3) step();
    chk("miso_before_reset", 32'(MISO), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_miso", 32'(MISO), 32'd0);
    chk("async_reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("async_reset_rx_data", 32'(rx_data), 32'd0);
    SS_n = 1'b1;
    step();
    rst_n = 1'b1;
    seen_m = 1'b0; last_rx = '0;
    step();
    cyc = -1; pulses = 0;
    SS_n = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'($urandom);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_reset_rx_data", 32'(rx_data), 32'd0);
    SS_n = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("midframe_reset_no_pulse", 32'(pulses), 32'd0);
    do_frame(10'h3A5, -1, 0, 0);
    do_frame(10'h13C, -1, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
